// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   UART frame serialiser. One byte is accepted per DATA_Valid while idle and
//   sent as start(0), DATA_WIDTH data bits LSB first, optional parity and one
//   stop(1) bit. Every bit lasts the latched Prescale count of CLK cycles.
//
// Ports
//   CLK         in   system clock, rising edge
//   RST         in   synchronous active-high reset
//   P_DATA      in   byte to send, sampled on the accept edge
//   DATA_Valid  in   send request, honoured only while idle
//   PAR_EN      in   1: insert parity bit after the data bits
//   PAR_TYP     in   0: even parity, 1: odd parity
//   Prescale    in   CLK cycles per bit (values below 4 behave as 4)
//   TX_OUT      out  serial line, idle high, registered
//   Busy        out  high while a frame is in flight, registered
module uart_tx_frame #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE   = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [5:0]            Prescale,
   output logic                  TX_OUT,
   output logic                  Busy
);

   // Counter wide enough for both the port range and the default period.
   localparam int CNT_W = ($clog2(PRESCALE + 1) > 6) ? $clog2(PRESCALE + 1) : 6;
   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                state, nxt_state;
   logic [CNT_W-1:0]      edge_cnt;
   logic [BIT_W-1:0]      bit_cnt, bit_nxt;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  par_en_q;
   logic                  par_bit_q;
   logic [CNT_W-1:0]      ps_q;
   logic [CNT_W-1:0]      ps_clamped;
   logic                  bit_end;
   logic                  last_bit;
   logic                  accept;
   logic                  tx_d;
   logic                  busy_d;

   assign ps_clamped = (Prescale < 6'd4) ? CNT_W'(4) : CNT_W'(Prescale);
   assign bit_end    = (edge_cnt == ps_q - 1'b1);
   assign last_bit   = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
   assign accept     = (state == S_IDLE) && DATA_Valid;

   // State, counters, frame latches and the registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         edge_cnt  <= '0;
         bit_cnt   <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         ps_q      <= CNT_W'(PRESCALE);
         TX_OUT    <= 1'b1;
         Busy      <= 1'b0;
      end else begin
         state   <= nxt_state;
         bit_cnt <= bit_nxt;
         // Free-runs 0..ps_q-1 in every active state, parked at 0 when idle.
         if (state == S_IDLE || bit_end)
            edge_cnt <= '0;
         else
            edge_cnt <= edge_cnt + 1'b1;
         if (accept) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_bit_q <= PAR_TYP ? ~^P_DATA : ^P_DATA;
            ps_q      <= ps_clamped;
         end
         TX_OUT <= tx_d;
         Busy   <= busy_d;
      end
   end

   // Next-state and next bit index.
   always_comb begin
      nxt_state = state;
      bit_nxt   = bit_cnt;
      case (state)
         S_IDLE: begin
            bit_nxt = '0;
            if (DATA_Valid) nxt_state = S_START;
         end
         S_START: begin
            if (bit_end) nxt_state = S_DATA;
         end
         S_DATA: begin
            if (bit_end) begin
               if (last_bit) begin
                  bit_nxt   = '0;
                  nxt_state = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_nxt = bit_cnt + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) nxt_state = S_STOP;
         end
         S_STOP: begin
            if (bit_end) nxt_state = S_IDLE;
         end
         default: begin
            nxt_state = S_IDLE;
            bit_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered line changes
   // on the same edge as the state, with no extra cycle of lag.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (nxt_state != S_IDLE);
      case (nxt_state)
         S_IDLE:   tx_d = 1'b1;
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = data_q[bit_nxt];
         S_PARITY: tx_d = par_bit_q;
         S_STOP:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] P_DATA = 8'h00;
   logic       DATA_Valid = 1'b0;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] Prescale = 6'd16;
   logic       TX_OUT;
   logic       Busy;

   int n_asrt = 0;
   int n_fail = 0;

   uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE(16)) dut (
      .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_Valid(DATA_Valid),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
      .TX_OUT(TX_OUT), .Busy(Busy)
   );

   always #5 CLK = ~CLK;

   // Called at a negedge; the following posedge is the accept edge.
   task automatic drive(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps; DATA_Valid = 1'b1;
   endtask

   // Checks every cycle of a frame against the expected bit string
   // (exp[0] = start bit). Optionally injects a busy-time request at inj_cyc.
   task automatic watch(input string tag, input logic [10:0] exp, input int nbits,
                        input int ps, input logic hold, input int inj_cyc,
                        input logic [7:0] inj_d);
      logic bad;
      logic tx_seen, busy_seen;
      bad = 1'b0; tx_seen = 1'b0; busy_seen = 1'b0;
      for (int c = 0; c < nbits * ps; c++) begin
         @(negedge CLK);
         if (c == 0 && !hold) DATA_Valid = 1'b0;
         if (c == inj_cyc) begin
            DATA_Valid = 1'b1; P_DATA = inj_d;
            PAR_EN = ~PAR_EN; PAR_TYP = ~PAR_TYP; Prescale = 6'd8;
         end
         if (c == inj_cyc + 1 && !hold) DATA_Valid = 1'b0;
         if (!bad && (TX_OUT !== exp[c / ps] || Busy !== 1'b1)) begin
            bad = 1'b1; tx_seen = TX_OUT; busy_seen = Busy;
         end
         if (c % ps == ps - 1) begin
            n_asrt++;
            if (bad) begin
               n_fail++;
               $display("FAIL %s bit%0d: TX_OUT=%b Busy=%b, required TX_OUT=%b Busy=1",
                        tag, c / ps, tx_seen, busy_seen, exp[c / ps]);
            end
            bad = 1'b0;
         end
      end
      @(negedge CLK);
      n_asrt++;
      if (Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s busy_len: Busy=%b after %0d cycles, required 0", tag, Busy, nbits * ps);
      end
      n_asrt++;
      if (TX_OUT !== 1'b1) begin
         n_fail++;
         $display("FAIL %s idle_line: TX_OUT=%b, required 1", tag, TX_OUT);
      end
   endtask

   task automatic test_reset();
      @(negedge CLK);
      RST = 1'b1; drive(8'h00, 1'b0, 1'b0, 6'd16);
      repeat (3) @(negedge CLK);
      DATA_Valid = 1'b0;
      n_asrt++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: TX_OUT=%b Busy=%b, required 1/0", TX_OUT, Busy);
      end
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      n_asrt++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: TX_OUT=%b Busy=%b, required 1/0", TX_OUT, Busy);
      end
   endtask

   task automatic test_even_a5();
      @(negedge CLK); drive(8'hA5, 1'b1, 1'b0, 6'd16);
      watch("even_a5", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 16, 1'b0, -1, 8'h00);
   endtask

   task automatic test_odd_00();
      @(negedge CLK); drive(8'h00, 1'b1, 1'b1, 6'd16);
      watch("odd_00", {1'b1, 1'b1, 8'h00, 1'b0}, 11, 16, 1'b0, -1, 8'h00);
   endtask

   task automatic test_nopar_3c();
      @(negedge CLK); drive(8'h3C, 1'b0, 1'b0, 6'd8);
      watch("nopar_3c", {1'b0, 1'b1, 8'h3C, 1'b0}, 10, 8, 1'b0, -1, 8'h00);
   endtask

   // Prescale=2 is below the floor and must run at 4 cycles per bit.
   task automatic test_clamp();
      @(negedge CLK); drive(8'h81, 1'b0, 1'b0, 6'd2);
      watch("clamp", {1'b0, 1'b1, 8'h81, 1'b0}, 10, 4, 1'b0, -1, 8'h00);
   endtask

   task automatic test_ignore_busy();
      logic stray;
      @(negedge CLK); drive(8'hA5, 1'b1, 1'b0, 6'd16);
      watch("ignore_busy", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 16, 1'b0, 40, 8'hFF);
      stray = 1'b0;
      repeat (40) begin
         @(negedge CLK);
         if (TX_OUT !== 1'b1 || Busy !== 1'b0) stray = 1'b1;
      end
      n_asrt++;
      if (stray) begin
         n_fail++;
         $display("FAIL ignore_busy_queued: line left idle after frame, required idle");
      end
   endtask

   // DATA_Valid held high for the whole first frame; the second byte is
   // accepted in the single idle cycle after Busy falls.
   task automatic test_back_to_back();
      @(negedge CLK); drive(8'hA5, 1'b1, 1'b0, 6'd16);
      watch("b2b_first", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 16, 1'b1, 20, 8'h77);
      drive(8'hFF, 1'b1, 1'b0, 6'd8);
      watch("b2b_second", {1'b1, 1'b0, 8'hFF, 1'b0}, 11, 8, 1'b0, -1, 8'h00);
   endtask

   task automatic test_mid_reset();
      @(negedge CLK); drive(8'hA5, 1'b1, 1'b0, 6'd16);
      @(negedge CLK); DATA_Valid = 1'b0;
      repeat (49) @(negedge CLK);
      RST = 1'b1; DATA_Valid = 1'b1;
      @(negedge CLK);
      n_asrt++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: TX_OUT=%b Busy=%b, required 1/0", TX_OUT, Busy);
      end
      RST = 1'b0; DATA_Valid = 1'b0;
      @(negedge CLK);
      n_asrt++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_wins: TX_OUT=%b Busy=%b, required 1/0", TX_OUT, Busy);
      end
      drive(8'hA5, 1'b1, 1'b0, 6'd16);
      watch("after_reset", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 16, 1'b0, -1, 8'h00);
   endtask

   // Receiver model sampling mid-bit from the falling start edge.
   task automatic rx_frame(input int ps, input logic pe, input logic pt,
                           output logic [7:0] b, output logic vld);
      int  t;
      logic ok;
      b = 8'h00; vld = 1'b0; t = 0;
      while (TX_OUT !== 1'b0 && t < 2000) begin @(negedge CLK); t++; end
      if (t >= 2000) return;
      repeat (ps / 2) @(negedge CLK);
      ok = (TX_OUT === 1'b0);
      for (int i = 0; i < 8; i++) begin
         repeat (ps) @(negedge CLK);
         b[i] = TX_OUT;
      end
      if (pe) begin
         repeat (ps) @(negedge CLK);
         if (TX_OUT !== (pt ? ~^b : ^b)) ok = 1'b0;
      end
      repeat (ps) @(negedge CLK);
      if (TX_OUT !== 1'b1) ok = 1'b0;
      vld = ok;
   endtask

   task automatic loop_one(input logic [7:0] d, input logic pe, input logic pt);
      logic [7:0] got;
      logic       vld;
      int         t;
      @(negedge CLK); drive(d, pe, pt, 6'd16);
      @(negedge CLK); DATA_Valid = 1'b0;
      rx_frame(16, pe, pt, got, vld);
      n_asrt++;
      if (got !== d) begin
         n_fail++;
         $display("FAIL loopback_data: got %h, required %h", got, d);
      end
      n_asrt++;
      if (vld !== 1'b1) begin
         n_fail++;
         $display("FAIL loopback_valid %h: valid=%b, required 1", d, vld);
      end
      t = 0;
      while (Busy !== 1'b0 && t < 200) begin @(negedge CLK); t++; end
      n_asrt++;
      if (Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL loopback_done %h: Busy=%b, required 0", d, Busy);
      end
   endtask

   task automatic test_loopback();
      loop_one(8'h55, 1'b1, 1'b1);
      loop_one(8'hA5, 1'b1, 1'b0);
      loop_one(8'h3C, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_even_a5();
      test_odd_00();
      test_nopar_3c();
      test_clamp();
      test_ignore_busy();
      test_back_to_back();
      test_mid_reset();
      test_loopback();
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
